zx_mem_mapper: RTL and testbench
================================

Name: zx_mem_mapper

Overview:
- Parametrised memory/IO mapper between the tv80n CPU bus and the banked RAM/ROM arrays.
- Generalises the fixed 48K decode to 48K, 128K and +2A/+3 paging: 16K RAM banks, selectable ROM banks, and the shadow screen.
- Holds port 7FFD, port 1FFD and ULA port FE state.
- Gives the SPI loader priority access to physical RAM while loading.

Parameters:
- MODE, 1, 0 = 48K fixed map, 1 = 128K (7FFD), 2 = +2A/+3 (7FFD + 1FFD)
- RAM_BANKS, 8, number of 16K RAM banks (power of 2, ≥ 8 when MODE > 0)
- BANK_W, 3, log2(RAM_BANKS)
- ROM_BANKS, 2, number of 16K ROM banks (1, 2 or 4)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- cpu_addr  in  16  CPU address
- cpu_dout  in  8  CPU write data
- n_mreq  in  1  CPU MREQ
- n_iorq  in  1  CPU IORQ
- n_wr  in  1  CPU WR
- ld_active  in  1  loader owns RAM and freezes port writes
- ld_addr  in  14+BANK_W  loader physical RAM address, {bank, offset}
- ld_we  in  1  loader write strobe
- mem_rom  out  1  1 = access targets ROM
- mem_bank  out  BANK_W  RAM bank, or ROM bank in the low bits
- mem_offset  out  14  offset within the 16K bank
- mem_we  out  1  RAM write enable; never asserted for ROM
- scr_bank  out  BANK_W  bank read by video: 5, or 7 when shadow screen is selected
- border  out  3  FE[2:0]
- mic  out  1  FE[3]
- ear  out  1  FE[4]
- paging_locked  out  1  7FFD[5] latched

Behaviour:
- Reset (reset_n=0 at a clk edge): all registers 0, so ROM 0, RAM bank 0 at C000, scr_bank = 5, border = 0, mic = ear = 0, unlocked, normal paging.
- IO write detect:
  - iowr = !n_iorq & !n_wr; iowr_d is a registered copy.
  - Strobe = iowr & !iowr_d, so exactly one strobe per CPU IO cycle however long IORQ is held.
  - The addressed register updates on the clk edge after the strobe cycle; a held IORQ never re-fires.
- Port FE (cpu_addr[0]=0): update border, mic, ear. Accepted in every MODE, regardless of lock.
- Port 7FFD (MODE ≥ 1):
  - MODE 1 decode: cpu_addr[15]=0 and cpu_addr[1]=0.
  - MODE 2 decode: cpu_addr[15:14]=01 and cpu_addr[1]=0.
  - Bits: [2:0] C000 bank, [3] screen, [4] ROM lo, [5] lock.
- Port 1FFD (MODE 2 only): cpu_addr[15:12]=0001 and cpu_addr[1]=0. Bits: [0] special, [2:1] config; bit 2 also drives ROM hi.
- Lock: while locked, 7FFD and 1FFD writes are ignored. Only reset clears the lock. Setting lock in the same write applies that write's other bits.
- Simultaneous decode of FE and 7FFD (e.g. address 0x7FFC): both registers update on the same strobe.
- ld_active=1:
  - Port strobes are ignored.
  - mem_rom=0, {mem_bank, mem_offset}=ld_addr, mem_we=ld_we.
  - Switching ld_active takes effect in the same cycle (combinational mux).
- Normal map (combinational from the registers and cpu_addr), with seg = cpu_addr[15:14]:
  - MODE 0: seg 0 → ROM 0; seg 1,2,3 → banks 5, 2, 0.
  - MODE 1/2 with special=0:
    - seg 0 → ROM index {1FFD[2], 7FFD[4]}, truncated to log2(ROM_BANKS) bits.
    - seg 1,2 → banks 5, 2; seg 3 → 7FFD[2:0].
  - MODE 2 with special=1, config gives the banks for seg 0..3, with no ROM:
    - config 0 → 0,1,2,3
    - config 1 → 4,5,6,7
    - config 2 → 4,5,6,3
    - config 3 → 4,7,6,3
  - mem_offset = cpu_addr[13:0].
  - mem_we = !n_mreq & !n_wr & !mem_rom.
- When RAM_BANKS > 8, upper bank bits are zero for all bank values above.
- scr_bank = 7FFD[3] ? 7 : 5. In MODE 0 it is always 5.
- paging_locked mirrors the lock register.

Decomposition:
- zx_pkg holds: MODE_48K/MODE_128K/MODE_PLUS3 constants; port decode masks; fixed bank numbers (5, 2, 7); and the four special-config bank tables as constant functions.
- One sub-module, zx_io_strobe: the edge detector producing a single-cycle write strobe from n_iorq/n_wr.

Test Plan:
- Reset, MODE 1, read 0x0000 → mem_rom=1, bank 0. Read 0xC123 → mem_rom=0, bank 0, offset 0x0123. scr_bank=5.
- OUT 0x7FFD,0x1F with IORQ held 6 clks → exactly one strobe. Then 0xC000 → bank 7, scr_bank=7, ROM 1.
- OUT 0x7FFD,0x20 then OUT 0x7FFD,0x03 → second write ignored, bank stays 0, paging_locked=1. Reset → unlocked, bank 0.
- MODE 2: OUT 0x1FFD,0x07 → segs 0..3 map to banks 4,7,6,3. A write to 0x0010 gives mem_we=1 on bank 4.
- OUT 0x7FFC,0x1A in MODE 1 → border=2, mic=1, ear=1, and the C000 bank becomes 2.
- ld_active=1, ld_addr=0x1C005, ld_we=1 → mem_bank=7, offset 0x0005, mem_we=1. Port writes during loading leave all registers unchanged.

Source files
------------

// File: rtl/zx_pkg.sv
// zx_pkg: shared constants and bank tables for the ZX Spectrum memory mapper
package zx_pkg;
  localparam int MODE_48K   = 0;
  localparam int MODE_128K  = 1;
  localparam int MODE_PLUS3 = 2;
  localparam logic [15:0] FE_MASK          = 16'h0001;
  localparam logic [15:0] FE_MATCH         = 16'h0000;
  localparam logic [15:0] P7FFD_128_MASK   = 16'h8002;
  localparam logic [15:0] P7FFD_128_MATCH  = 16'h0000;
  localparam logic [15:0] P7FFD_P3_MASK    = 16'hC002;
  localparam logic [15:0] P7FFD_P3_MATCH   = 16'h4000;
  localparam logic [15:0] P1FFD_MASK       = 16'hF002;
  localparam logic [15:0] P1FFD_MATCH      = 16'h1000;
  localparam logic [2:0] BANK_SCREEN = 3'd5;
  localparam logic [2:0] BANK_MID    = 3'd2;
  localparam logic [2:0] BANK_SHADOW = 3'd7;
  // Octal digits list the banks for seg 3..0, most significant first
  function automatic logic [11:0] special_table(input logic [1:0] cfg);
    return cfg == 2'd0 ? 12'o3210 : cfg == 2'd1 ? 12'o7654 : cfg == 2'd2 ? 12'o3654 : 12'o3674;
  endfunction
  function automatic logic [2:0] special_bank(input logic [1:0] cfg, input logic [1:0] seg);
    logic [11:0] t;
    t = special_table(cfg);
    return t[int'(seg) * 3 +: 3];
  endfunction
endpackage

// File: rtl/zx_io_strobe.sv
// zx_io_strobe: one-cycle write strobe per CPU IO write cycle
module zx_io_strobe (
  input  logic clk,
  input  logic reset_n,
  input  logic n_iorq,
  input  logic n_wr,
  output logic strobe
);
  logic iowr, iowr_d, iowr_q;
  always_comb begin
    iowr = !n_iorq && !n_wr;
    iowr_d = iowr;
    strobe = iowr && !iowr_q;
  end
  always_ff @(posedge clk)
    iowr_q <= reset_n ? iowr_d : 1'b0;
endmodule

// File: rtl/zx_mem_mapper.sv
// zx_mem_mapper: CPU/loader to banked RAM/ROM mapper with 48K, 128K and +2A/+3 paging
module zx_mem_mapper
  import zx_pkg::*;
#(
  parameter int MODE      = 1,
  parameter int RAM_BANKS = 8,
  parameter int BANK_W    = 3,
  parameter int ROM_BANKS = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [15:0]          cpu_addr,
  input  logic [7:0]           cpu_dout,
  input  logic                 n_mreq,
  input  logic                 n_iorq,
  input  logic                 n_wr,
  input  logic                 ld_active,
  input  logic [14+BANK_W-1:0] ld_addr,
  input  logic                 ld_we,
  output logic                 mem_rom,
  output logic [BANK_W-1:0]    mem_bank,
  output logic [13:0]          mem_offset,
  output logic                 mem_we,
  output logic [BANK_W-1:0]    scr_bank,
  output logic [2:0]           border,
  output logic                 mic,
  output logic                 ear,
  output logic                 paging_locked
);
  localparam logic [1:0] ROM_MASK = 2'(ROM_BANKS - 1);
  logic strobe, port_wr, lock, special, rom3;
  logic hit_fe, hit_7ffd, hit_1ffd;
  logic [5:0] p7ffd_q, p7ffd_d;
  logic [2:0] p1ffd_q, p1ffd_d;
  logic [4:0] fe_q, fe_d;
  logic [1:0] seg, rom_idx;
  logic [2:0] bank3;
  logic unused_ok;
  zx_io_strobe u_strobe (
    .clk(clk),
    .reset_n(reset_n),
    .n_iorq(n_iorq),
    .n_wr(n_wr),
    .strobe(strobe)
  );
  always_comb begin
    lock = p7ffd_q[5];
    port_wr = strobe && !ld_active;
    hit_fe = (cpu_addr & FE_MASK) == FE_MATCH;
    hit_7ffd = MODE == MODE_128K ? (cpu_addr & P7FFD_128_MASK) == P7FFD_128_MATCH :
               MODE == MODE_PLUS3 ? (cpu_addr & P7FFD_P3_MASK) == P7FFD_P3_MATCH : 1'b0;
    hit_1ffd = MODE == MODE_PLUS3 && (cpu_addr & P1FFD_MASK) == P1FFD_MATCH;
    fe_d = port_wr && hit_fe ? cpu_dout[4:0] : fe_q;
    p7ffd_d = port_wr && hit_7ffd && !lock ? cpu_dout[5:0] : p7ffd_q;
    p1ffd_d = port_wr && hit_1ffd && !lock ? cpu_dout[2:0] : p1ffd_q;
    seg = cpu_addr[15:14];
    rom_idx = MODE == MODE_48K ? 2'd0 : {p1ffd_q[2], p7ffd_q[4]} & ROM_MASK;
    special = MODE == MODE_PLUS3 && p1ffd_q[0];
    rom3 = !special && seg == 2'd0;
    bank3 = special ? special_bank(p1ffd_q[2:1], seg) :
            seg == 2'd0 ? {1'b0, rom_idx} :
            seg == 2'd1 ? BANK_SCREEN :
            seg == 2'd2 ? BANK_MID :
            MODE == MODE_48K ? 3'd0 : p7ffd_q[2:0];
    mem_rom = !ld_active && rom3;
    {mem_bank, mem_offset} = ld_active ? ld_addr : {BANK_W'(bank3), cpu_addr[13:0]};
    mem_we = ld_active ? ld_we : !n_mreq && !n_wr && !rom3;
    scr_bank = BANK_W'(MODE != MODE_48K && p7ffd_q[3] ? BANK_SHADOW : BANK_SCREEN);
    border = fe_q[2:0];
    mic = fe_q[3];
    ear = fe_q[4];
    paging_locked = lock;
    unused_ok = &{1'b0, cpu_dout[7:6], RAM_BANKS == (1 << BANK_W)};
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      p7ffd_q <= '0;
      p1ffd_q <= '0;
      fe_q <= '0;
    end else begin
      p7ffd_q <= p7ffd_d;
      p1ffd_q <= p1ffd_d;
      fe_q <= fe_d;
    end
endmodule

// File: tb/tb_zx_mem_mapper.sv
// tb_zx_mem_mapper: 48K, 128K and +3 mappers side by side on one shared CPU/loader bus
module tb_zx_mem_mapper;
  typedef struct packed {
    logic rom;
    logic [2:0] bank;
    logic [13:0] off;
    logic we;
    logic [2:0] scr;
    logic [2:0] brd;
    logic mic;
    logic ear;
    logic lock;
  } obs_t;
  typedef struct {
    int d;
    string nm;
    logic [15:0] a;
    logic mr;
    logic wr;
    obs_t e;
  } vec_t;
  typedef struct {
    int d;
    string nm;
    obs_t e;
  } exp_t;

  logic clk = 1'b0, reset_n = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0] cpu_dout = '0;
  logic n_mreq = 1'b1, n_iorq = 1'b1, n_wr = 1'b1;
  logic ld_active = 1'b0, ld_we = 1'b0;
  logic [16:0] ld_addr = '0;
  logic m_rom[3], m_we[3], m_mic[3], m_ear[3], m_lock[3];
  logic [2:0] m_bank[3], m_scr[3], m_brd[3];
  logic [13:0] m_off[3];
  int n_checks = 0, n_fail = 0;
  exp_t sb[$];
  vec_t tbl[13];

  always #5 clk = ~clk;

  zx_mem_mapper #(.MODE(0), .RAM_BANKS(8), .BANK_W(3), .ROM_BANKS(2)) u_48 (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .n_mreq(n_mreq), .n_iorq(n_iorq), .n_wr(n_wr), .ld_active(ld_active),
    .ld_addr(ld_addr), .ld_we(ld_we), .mem_rom(m_rom[0]), .mem_bank(m_bank[0]),
    .mem_offset(m_off[0]), .mem_we(m_we[0]), .scr_bank(m_scr[0]), .border(m_brd[0]),
    .mic(m_mic[0]), .ear(m_ear[0]), .paging_locked(m_lock[0]));
  zx_mem_mapper #(.MODE(1), .RAM_BANKS(8), .BANK_W(3), .ROM_BANKS(2)) u_128 (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .n_mreq(n_mreq), .n_iorq(n_iorq), .n_wr(n_wr), .ld_active(ld_active),
    .ld_addr(ld_addr), .ld_we(ld_we), .mem_rom(m_rom[1]), .mem_bank(m_bank[1]),
    .mem_offset(m_off[1]), .mem_we(m_we[1]), .scr_bank(m_scr[1]), .border(m_brd[1]),
    .mic(m_mic[1]), .ear(m_ear[1]), .paging_locked(m_lock[1]));
  zx_mem_mapper #(.MODE(2), .RAM_BANKS(8), .BANK_W(3), .ROM_BANKS(4)) u_p3 (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .n_mreq(n_mreq), .n_iorq(n_iorq), .n_wr(n_wr), .ld_active(ld_active),
    .ld_addr(ld_addr), .ld_we(ld_we), .mem_rom(m_rom[2]), .mem_bank(m_bank[2]),
    .mem_offset(m_off[2]), .mem_we(m_we[2]), .scr_bank(m_scr[2]), .border(m_brd[2]),
    .mic(m_mic[2]), .ear(m_ear[2]), .paging_locked(m_lock[2]));

  function automatic obs_t mk(logic rom, logic [2:0] bank, logic [13:0] off, logic we,
                              logic [2:0] scr, logic [2:0] brd, logic mic, logic ear, logic lock);
    return '{rom, bank, off, we, scr, brd, mic, ear, lock};
  endfunction

  function automatic obs_t get(int d);
    return '{m_rom[d], m_bank[d], m_off[d], m_we[d], m_scr[d], m_brd[d], m_mic[d], m_ear[d], m_lock[d]};
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("rom=%0d bank=%0d off=%h we=%0d scr=%0d border=%0d mic=%0d ear=%0d lock=%0d",
                     o.rom, o.bank, o.off, o.we, o.scr, o.brd, o.mic, o.ear, o.lock);
  endfunction

  task automatic drain();
    exp_t x;
    obs_t got;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      got = get(x.d);
      n_checks++;
      if (got !== x.e) begin
        n_fail++;
        $display("FAIL %s (dut %0d): got %s, expected %s", x.nm, x.d, fmt(got), fmt(x.e));
      end
    end
  endtask

  task automatic chk(input vec_t v);
    cpu_addr = v.a;
    n_mreq = v.mr;
    n_wr = v.wr;
    sb.push_back('{v.d, v.nm, v.e});
    @(negedge clk);
    drain();
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] dt, input int hold, input logic [7:0] late);
    @(posedge clk);
    #1;
    cpu_addr = a;
    cpu_dout = dt;
    n_mreq = 1'b1;
    n_iorq = 1'b0;
    n_wr = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) cpu_dout = late;
    end
    n_iorq = 1'b1;
    n_wr = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1, "m1_rom_0000",  16'h0000, 1'b0, 1'b1, mk(1, 0, 14'h0000, 0, 5, 0, 0, 0, 0)};
    tbl[1]  = '{1, "m1_c123",      16'hC123, 1'b0, 1'b1, mk(0, 0, 14'h0123, 0, 5, 0, 0, 0, 0)};
    tbl[2]  = '{1, "m1_4000",      16'h4000, 1'b0, 1'b1, mk(0, 5, 14'h0000, 0, 5, 0, 0, 0, 0)};
    tbl[3]  = '{1, "m1_8abc",      16'h8ABC, 1'b0, 1'b1, mk(0, 2, 14'h0ABC, 0, 5, 0, 0, 0, 0)};
    tbl[4]  = '{1, "m1_wr_c000",   16'hC000, 1'b0, 1'b0, mk(0, 0, 14'h0000, 1, 5, 0, 0, 0, 0)};
    tbl[5]  = '{1, "m1_wr_rom",    16'h0000, 1'b0, 1'b0, mk(1, 0, 14'h0000, 0, 5, 0, 0, 0, 0)};
    tbl[6]  = '{0, "m0_rom_0000",  16'h0000, 1'b0, 1'b1, mk(1, 0, 14'h0000, 0, 5, 0, 0, 0, 0)};
    tbl[7]  = '{0, "m0_4001",      16'h4001, 1'b0, 1'b1, mk(0, 5, 14'h0001, 0, 5, 0, 0, 0, 0)};
    tbl[8]  = '{0, "m0_8000",      16'h8000, 1'b0, 1'b1, mk(0, 2, 14'h0000, 0, 5, 0, 0, 0, 0)};
    tbl[9]  = '{0, "m0_ffff",      16'hFFFF, 1'b0, 1'b1, mk(0, 0, 14'h3FFF, 0, 5, 0, 0, 0, 0)};
    tbl[10] = '{0, "m0_wr_4001",   16'h4001, 1'b0, 1'b0, mk(0, 5, 14'h0001, 1, 5, 0, 0, 0, 0)};
    tbl[11] = '{2, "m2_rom_2000",  16'h2000, 1'b0, 1'b1, mk(1, 0, 14'h2000, 0, 5, 0, 0, 0, 0)};
    tbl[12] = '{2, "m2_wr_nomreq", 16'hC000, 1'b1, 1'b0, mk(0, 0, 14'h0000, 0, 5, 0, 0, 0, 0)};
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 13; i++) chk(tbl[i]);
    // Data changes mid-cycle: a second strobe would page bank 0 back in
    io_write(16'h7FFD, 8'h1F, 6, 8'h00);
    chk('{1, "strobe_once_c000", 16'hC000, 1'b0, 1'b1, mk(0, 7, 14'h0000, 0, 7, 0, 0, 0, 0)});
    chk('{1, "rom1_sel",         16'h0000, 1'b0, 1'b1, mk(1, 1, 14'h0000, 0, 7, 0, 0, 0, 0)});
    chk('{2, "p3_rom1_sel",      16'h0000, 1'b0, 1'b1, mk(1, 1, 14'h0000, 0, 7, 0, 0, 0, 0)});
    chk('{0, "m0_ignores_7ffd",  16'h4000, 1'b0, 1'b1, mk(0, 5, 14'h0000, 0, 5, 0, 0, 0, 0)});
    io_write(16'h7FFD, 8'h20, 1, 8'h20);
    io_write(16'h7FFD, 8'h03, 1, 8'h03);
    io_write(16'h1FFD, 8'h07, 1, 8'h07);
    chk('{1, "locked_c000",      16'hC000, 1'b0, 1'b1, mk(0, 0, 14'h0000, 0, 5, 0, 0, 0, 1)});
    chk('{1, "locked_rom0",      16'h0000, 1'b0, 1'b1, mk(1, 0, 14'h0000, 0, 5, 0, 0, 0, 1)});
    chk('{2, "locked_1ffd",      16'h4000, 1'b0, 1'b1, mk(0, 5, 14'h0000, 0, 5, 0, 0, 0, 1)});
    do_reset();
    chk('{1, "unlock_reset",     16'hC000, 1'b0, 1'b1, mk(0, 0, 14'h0000, 0, 5, 0, 0, 0, 0)});
    chk('{2, "p3_unlock_reset",  16'h4000, 1'b0, 1'b1, mk(0, 5, 14'h0000, 0, 5, 0, 0, 0, 0)});
    io_write(16'h1FFD, 8'h07, 1, 8'h07);
    chk('{2, "cfg3_seg0",        16'h0000, 1'b0, 1'b1, mk(0, 4, 14'h0000, 0, 5, 0, 0, 0, 0)});
    chk('{2, "cfg3_seg1",        16'h4000, 1'b0, 1'b1, mk(0, 7, 14'h0000, 0, 5, 0, 0, 0, 0)});
    chk('{2, "cfg3_seg2",        16'h8000, 1'b0, 1'b1, mk(0, 6, 14'h0000, 0, 5, 0, 0, 0, 0)});
    chk('{2, "cfg3_seg3",        16'hC000, 1'b0, 1'b1, mk(0, 3, 14'h0000, 0, 5, 0, 0, 0, 0)});
    chk('{2, "cfg3_wr_0010",     16'h0010, 1'b0, 1'b0, mk(0, 4, 14'h0010, 1, 5, 0, 0, 0, 0)});
    io_write(16'h1FFD, 8'h05, 1, 8'h05);
    chk('{2, "cfg2_seg1",        16'h4000, 1'b0, 1'b1, mk(0, 5, 14'h0000, 0, 5, 0, 0, 0, 0)});
    chk('{2, "cfg2_seg3",        16'hC000, 1'b0, 1'b1, mk(0, 3, 14'h0000, 0, 5, 0, 0, 0, 0)});
    io_write(16'h1FFD, 8'h01, 1, 8'h01);
    chk('{2, "cfg0_seg0",        16'h0000, 1'b0, 1'b1, mk(0, 0, 14'h0000, 0, 5, 0, 0, 0, 0)});
    chk('{2, "cfg0_seg1",        16'h4000, 1'b0, 1'b1, mk(0, 1, 14'h0000, 0, 5, 0, 0, 0, 0)});
    io_write(16'h1FFD, 8'h04, 1, 8'h04);
    chk('{2, "rom_hi_sel",       16'h0000, 1'b0, 1'b1, mk(1, 2, 14'h0000, 0, 5, 0, 0, 0, 0)});
    io_write(16'h7FFC, 8'h1A, 1, 8'h1A);
    chk('{1, "fe_7ffd_both",     16'hC000, 1'b0, 1'b1, mk(0, 2, 14'h0000, 0, 7, 2, 1, 1, 0)});
    chk('{0, "m0_fe",            16'hC000, 1'b0, 1'b1, mk(0, 0, 14'h0000, 0, 5, 2, 1, 1, 0)});
    chk('{2, "p3_rom3",          16'h0000, 1'b0, 1'b1, mk(1, 3, 14'h0000, 0, 7, 2, 1, 1, 0)});
    ld_active = 1'b1;
    ld_addr = 17'h1C005;
    ld_we = 1'b1;
    chk('{1, "ld_map_we",        16'h0000, 1'b1, 1'b1, mk(0, 7, 14'h0005, 1, 7, 2, 1, 1, 0)});
    chk('{0, "m0_ld_map_we",     16'h0000, 1'b1, 1'b1, mk(0, 7, 14'h0005, 1, 5, 2, 1, 1, 0)});
    io_write(16'h7FFC, 8'h00, 1, 8'h00);
    io_write(16'h7FFD, 8'h20, 1, 8'h20);
    ld_we = 1'b0;
    chk('{1, "ld_no_we",         16'hC000, 1'b0, 1'b0, mk(0, 7, 14'h0005, 0, 7, 2, 1, 1, 0)});
    ld_active = 1'b0;
    chk('{1, "ld_ports_frozen",  16'hC000, 1'b0, 1'b0, mk(0, 2, 14'h0000, 1, 7, 2, 1, 1, 0)});
    chk('{0, "m0_ld_fe_frozen",  16'h8000, 1'b0, 1'b1, mk(0, 2, 14'h0000, 0, 5, 2, 1, 1, 0)});
    io_write(16'h7FFD, 8'h20, 1, 8'h20);
    io_write(16'h7FFC, 8'h05, 1, 8'h05);
    chk('{1, "fe_while_locked",  16'hC000, 1'b0, 1'b1, mk(0, 0, 14'h0000, 0, 5, 5, 0, 0, 1)});
    chk('{0, "m0_fe_update",     16'hC000, 1'b0, 1'b1, mk(0, 0, 14'h0000, 0, 5, 5, 0, 0, 0)});
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
